load_rs_array: RTL and testbench
================================

Name: load_rs_array

Overview:
- Parametrised load reservation station holding NUM_ENTRIES in-flight loads between dispatch and the load/store unit.
- Each slot tracks an optional store dependency, then the base-register readiness.
- Issues the oldest ready load, by ROB age relative to rob_head, through a valid/ready handshake.
- Supports a full-pipeline flush; successor to the single-slot load RS entry.

Parameters:
NUM_ENTRIES, 8, number of load slots (power of two, >=2)
ROB_IDX_W, 5, width of ROB index fields; ROB wraps modulo 2**ROB_IDX_W
NUM_PHYS_REGS, 64, physical register count (width of valid_reg)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
flush  in  1  discard every entry (branch mispredict/exception)
dispatch_valid  in  1  dispatch presents a load this cycle
dispatch_entry  in  load_rs_entry_t  load to insert (ps1_s, has_store_dep, store_dependency, rob_num, pd, imm, funct3)
dispatch_ready  out  1  at least one slot EMPTY (registered-state based)
valid_reg  in  NUM_PHYS_REGS  physical register ready vector
store_load_cdb  in  cdb_t  store completion broadcast (valid, rob_num)
rob_head  in  ROB_IDX_W  oldest ROB index, used for age compare
issue_valid  out  1  a READY slot is selected
issue_entry  out  load_rs_entry_t  selected load
issue_ready  in  1  LSU accepts issue_entry this cycle
occupancy  out  $clog2(NUM_ENTRIES)+1  count of non-EMPTY slots

Behaviour:
- Per-slot states: EMPTY, WAIT_FOR_STORE, WAIT_FOR_REG, READY.
- Reset:
  - All slots go EMPTY on the edge where rst=1.
  - dispatch_ready=1, issue_valid=0, occupancy=0 after reset.
  - issue_entry is don't-care while issue_valid=0.
- Flush: identical effect to reset.
  - A dispatch or issue in the flush cycle has no effect on slot state.
  - rst dominates flush.
- Dispatch:
  - When dispatch_valid && dispatch_ready, write the lowest-index EMPTY slot.
  - Initial state is resolved from the same-cycle inputs:
    - has_store_dep=1 and no matching store_load_cdb: WAIT_FOR_STORE.
    - else valid_reg[ps1_s]=0: WAIT_FOR_REG.
    - else: READY.
  - Dispatch when dispatch_ready=0 is ignored.
  - Dispatching into a full array is a protocol violation; assert it in simulation.
- WAIT_FOR_STORE -> WAIT_FOR_REG when store_load_cdb.valid && store_load_cdb.rob_num==store_dependency.
  - Goes directly to READY if valid_reg[ps1_s]=1 in that same cycle.
- WAIT_FOR_REG -> READY when valid_reg[ps1_s]=1.
- READY -> EMPTY on the edge where the slot is selected and issue_ready=1.
- Selection (combinational from registered state):
  - Age = (rob_num - rob_head) mod 2**ROB_IDX_W; the smallest age among READY slots wins.
  - Ties are impossible (unique ROB numbers); lowest slot index breaks any tie defensively.
  - issue_valid = any READY slot.
  - issue_entry is stable while issue_valid=1 && issue_ready=0, unless an older slot becomes READY.
- A slot freed by issue is not reusable until the next cycle: dispatch_ready uses registered state. Latency from issue to the slot's reuse is 1 cycle.
- Minimum dispatch-to-issue latency: 1 cycle. A load dispatched READY presents on issue_valid the following cycle.
- occupancy is a registered count updated each cycle: +1 on accepted dispatch, -1 on accepted issue, both together give net 0. Range 0..NUM_ENTRIES.
- Store broadcasts matching no slot are ignored.
- One broadcast may wake multiple slots.

Decomposition:
- rv32i_types: rs_state_t (EMPTY/WAIT_FOR_STORE/WAIT_FOR_REG/READY), load_rs_entry_t (add has_store_dep bit), cdb_t.
- Sub-module load_rs_slot: one slot's register and next-state logic.
  - Inputs: we, clear, issue_ack, valid_reg, store_load_cdb, input_entry.
  - Output: output_entry.
  - Instantiated NUM_ENTRIES times via generate.
- Top level holds the free-slot priority encoder, age-compare select tree, and occupancy counter.

Test Plan:
- Reset, then dispatch ps1=3 (valid_reg[3]=1, has_store_dep=0, rob_num=4): issue_valid=1 next cycle with rob_num 4; issue_ready=1 -> occupancy back to 0.
- Dispatch load rob_num=7, has_store_dep=1, store_dependency=6, valid_reg[ps1]=0:
  - Stays WAIT_FOR_STORE until CDB rob_num=6 arrives.
  - Then waits for valid_reg[ps1]; issue_valid rises 1 cycle after valid_reg sets.
- Age with wrap (ROB_IDX_W=5, rob_head=30): READY slots rob_num 31, 1, 30 in slots 0,1,2 -> issue order 30, 31, 1 with issue_ready held 1.
- Fill all 8 slots with blocked loads -> dispatch_ready=0, occupancy=8. Extra dispatch ignored. Wake one and issue -> dispatch_ready=1 the cycle after.
- Same-cycle dispatch (has_store_dep=1, dep=2) with store_load_cdb rob_num=2 and valid_reg set -> slot enters READY directly; issue next cycle.
- Flush with 5 occupied slots plus a concurrent dispatch -> next cycle occupancy=0, issue_valid=0, dispatch_ready=1.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the load reservation station: slot states,
// the dispatched load bundle and the store-completion broadcast.
package rv32i_types;

    localparam int ROB_W    = 5;
    localparam int PREG_CNT = 64;
    localparam int PREG_W   = $clog2(PREG_CNT);

    typedef enum logic [1:0] {
        EMPTY,
        WAIT_FOR_STORE,
        WAIT_FOR_REG,
        READY
    } rs_state_t;

    typedef struct packed {
        logic [PREG_W-1:0] ps1_s;
        logic              has_store_dep;
        logic [ROB_W-1:0]  store_dependency;
        logic [ROB_W-1:0]  rob_num;
        logic [PREG_W-1:0] pd;
        logic [31:0]       imm;
        logic [2:0]        funct3;
    } load_rs_entry_t;

    typedef struct packed {
        logic             valid;
        logic [ROB_W-1:0] rob_num;
    } cdb_t;

    // Where a load lands given this cycle's store broadcast and reg readiness.
    function automatic rs_state_t resolve_state(
        input load_rs_entry_t      e,
        input logic [PREG_CNT-1:0] vreg,
        input cdb_t                cdb
    );
        if (e.has_store_dep && !(cdb.valid && cdb.rob_num == e.store_dependency))
            return WAIT_FOR_STORE;
        else if (!vreg[e.ps1_s])
            return WAIT_FOR_REG;
        else
            return READY;
    endfunction

endpackage

// File: rtl/load_rs_slot.sv
// One load reservation slot: holds the load and walks it from
// store-dependency wait, through base-register wait, to ready.
module load_rs_slot
    import rv32i_types::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic                clear,
    input  logic                issue_ack,
    input  logic [PREG_CNT-1:0] valid_reg,
    input  cdb_t                store_load_cdb,
    input  load_rs_entry_t      input_entry,
    output load_rs_entry_t      output_entry,
    output rs_state_t           state_o
);

    rs_state_t      state_q, state_d;
    load_rs_entry_t entry_q, entry_d;

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        if (clear) begin
            state_d = EMPTY;
        end else if (we) begin
            entry_d = input_entry;
            state_d = resolve_state(input_entry, valid_reg, store_load_cdb);
        end else begin
            unique case (state_q)
                WAIT_FOR_STORE: state_d = resolve_state(entry_q, valid_reg, store_load_cdb);
                WAIT_FOR_REG:   if (valid_reg[entry_q.ps1_s]) state_d = READY;
                READY:          if (issue_ack) state_d = EMPTY;
                default:        state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
        end
    end

    assign output_entry = entry_q;
    assign state_o      = state_q;

endmodule

// File: rtl/load_rs_array.sv
// Load reservation station: free-slot allocation, oldest-ready
// selection by ROB age relative to the head, and occupancy count.
module load_rs_array
    import rv32i_types::*;
#(
    parameter int NUM_ENTRIES   = 8,
    parameter int ROB_IDX_W     = ROB_W,
    parameter int NUM_PHYS_REGS = PREG_CNT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             dispatch_valid,
    input  load_rs_entry_t                   dispatch_entry,
    output logic                             dispatch_ready,
    input  logic [NUM_PHYS_REGS-1:0]         valid_reg,
    input  cdb_t                             store_load_cdb,
    input  logic [ROB_IDX_W-1:0]             rob_head,
    output logic                             issue_valid,
    output load_rs_entry_t                   issue_entry,
    input  logic                             issue_ready,
    output logic [$clog2(NUM_ENTRIES):0]     occupancy
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int OCC_W = IDX_W + 1;

    rs_state_t            st  [NUM_ENTRIES];
    load_rs_entry_t       ent [NUM_ENTRIES];
    logic [ROB_IDX_W-1:0] age [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] we, ack;

    logic             free_found, sel_found;
    logic [IDX_W-1:0] free_idx, sel_idx;
    logic [ROB_IDX_W-1:0] best_age;
    logic             acc_disp, acc_iss;
    logic [OCC_W-1:0] occ_q, occ_d;

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_slot
        assign we[i]  = acc_disp && !flush && free_idx == IDX_W'(i);
        assign ack[i] = acc_iss && sel_idx == IDX_W'(i);
        assign age[i] = ent[i].rob_num - rob_head;

        load_rs_slot u_slot (
            .clk            (clk),
            .rst            (rst),
            .we             (we[i]),
            .clear          (flush),
            .issue_ack      (ack[i]),
            .valid_reg      (valid_reg),
            .store_load_cdb (store_load_cdb),
            .input_entry    (dispatch_entry),
            .output_entry   (ent[i]),
            .state_o        (st[i])
        );
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!free_found && st[i] == EMPTY) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Strict less-than keeps the lowest slot index on an age tie.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (st[i] == READY && (!sel_found || age[i] < best_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = age[i];
            end
        end
    end

    assign dispatch_ready = free_found;
    assign issue_valid    = sel_found;
    assign issue_entry    = ent[sel_idx];
    assign acc_disp       = dispatch_valid && dispatch_ready;
    assign acc_iss        = issue_valid && issue_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush)
            occ_d = '0;
        else if (acc_disp && !acc_iss)
            occ_d = occ_q + OCC_W'(1);
        else if (acc_iss && !acc_disp)
            occ_d = occ_q - OCC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) occ_q <= '0;
        else     occ_q <= occ_d;
    end

    assign occupancy = occ_q;

    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(dispatch_valid && !dispatch_ready))
            else $warning("load_rs_array: dispatch into full array dropped");
    end

endmodule

// File: tb/tb_load_rs_array.sv
// Directed bench for load_rs_array: wake-up paths, age order with
// ROB wrap, full array, same-cycle wake at dispatch, and flush.
module tb_load_rs_array;
    import rv32i_types::*;

    logic           clk = 1'b0;
    logic           rst, flush, dispatch_valid, dispatch_ready;
    load_rs_entry_t dispatch_entry, issue_entry;
    logic [63:0]    valid_reg;
    cdb_t           store_load_cdb;
    logic [4:0]     rob_head;
    logic           issue_valid, issue_ready;
    logic [3:0]     occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_rs_array dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .dispatch_valid (dispatch_valid),
        .dispatch_entry (dispatch_entry),
        .dispatch_ready (dispatch_ready),
        .valid_reg      (valid_reg),
        .store_load_cdb (store_load_cdb),
        .rob_head       (rob_head),
        .issue_valid    (issue_valid),
        .issue_entry    (issue_entry),
        .issue_ready    (issue_ready),
        .occupancy      (occupancy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic load_rs_entry_t mk(input int ps1, input bit dep,
                                          input int dep_rob, input int rob);
        load_rs_entry_t e;
        e                  = '0;
        e.ps1_s            = PREG_W'(ps1);
        e.has_store_dep    = dep;
        e.store_dependency = ROB_W'(dep_rob);
        e.rob_num          = ROB_W'(rob);
        e.pd               = PREG_W'(rob + 32);
        e.imm              = 32'(rob * 4);
        e.funct3           = 3'b010;
        return e;
    endfunction

    task automatic disp(input load_rs_entry_t e);
        dispatch_entry = e;
        dispatch_valid = 1'b1;
        step();
        dispatch_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; dispatch_valid = 1'b0;
        dispatch_entry = '0; valid_reg = '0; store_load_cdb = '0;
        rob_head = '0; issue_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_dready", int'(dispatch_ready), 1);
        chk("rst_ivalid", int'(issue_valid), 0);
        chk("rst_occ", int'(occupancy), 0);

        // Ready-at-dispatch load issues the next cycle.
        valid_reg[3] = 1'b1;
        disp(mk(3, 0, 0, 4));
        chk("t1_ivalid", int'(issue_valid), 1);
        chk("t1_rob", int'(issue_entry.rob_num), 4);
        chk("t1_occ", int'(occupancy), 1);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        chk("t1_occ_after", int'(occupancy), 0);
        chk("t1_ivalid_after", int'(issue_valid), 0);

        // Store dependency, then base-register wait.
        disp(mk(10, 1, 6, 7));
        chk("t2_wfs", int'(issue_valid), 0);
        chk("t2_occ", int'(occupancy), 1);
        store_load_cdb = '{valid: 1'b1, rob_num: 5'd5};
        step();
        chk("t2_nomatch", int'(issue_valid), 0);
        store_load_cdb = '{valid: 1'b1, rob_num: 5'd6};
        step();
        store_load_cdb = '0;
        chk("t2_wfr", int'(issue_valid), 0);
        step();
        chk("t2_wfr_hold", int'(issue_valid), 0);
        valid_reg[10] = 1'b1;
        step();
        chk("t2_ivalid", int'(issue_valid), 1);
        chk("t2_rob", int'(issue_entry.rob_num), 7);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        valid_reg[10] = 1'b0;
        chk("t2_occ_after", int'(occupancy), 0);

        // Store wait holds even with the register already ready.
        disp(mk(3, 1, 9, 8));
        chk("t2b_wfs", int'(issue_valid), 0);
        store_load_cdb = '{valid: 1'b1, rob_num: 5'd9};
        step();
        store_load_cdb = '0;
        chk("t2b_direct", int'(issue_valid), 1);
        chk("t2b_rob", int'(issue_entry.rob_num), 8);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;

        // Age order across the ROB wrap.
        rob_head = 5'd30;
        disp(mk(3, 0, 0, 31));
        disp(mk(3, 0, 0, 1));
        disp(mk(3, 0, 0, 30));
        chk("t3_occ", int'(occupancy), 3);
        chk("t3_first", int'(issue_entry.rob_num), 30);
        issue_ready = 1'b1;
        step();
        chk("t3_second", int'(issue_entry.rob_num), 31);
        step();
        chk("t3_third", int'(issue_entry.rob_num), 1);
        step();
        issue_ready = 1'b0;
        chk("t3_empty", int'(issue_valid), 0);
        chk("t3_occ_after", int'(occupancy), 0);

        // Fill every slot with register-blocked loads.
        rob_head = '0;
        for (int i = 0; i < 8; i++) disp(mk(20 + i, 0, 0, 10 + i));
        chk("t4_dready", int'(dispatch_ready), 0);
        chk("t4_occ", int'(occupancy), 8);
        disp(mk(3, 0, 0, 20));
        chk("t4_extra_occ", int'(occupancy), 8);
        chk("t4_extra_iv", int'(issue_valid), 0);
        valid_reg[25] = 1'b1;
        step();
        chk("t4_wake", int'(issue_valid), 1);
        chk("t4_rob", int'(issue_entry.rob_num), 15);
        chk("t4_dready_pre", int'(dispatch_ready), 0);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        chk("t4_dready_post", int'(dispatch_ready), 1);
        chk("t4_occ_post", int'(occupancy), 7);

        // Store broadcast and register both ready at dispatch.
        store_load_cdb = '{valid: 1'b1, rob_num: 5'd2};
        disp(mk(3, 1, 2, 2));
        store_load_cdb = '0;
        chk("t5_ivalid", int'(issue_valid), 1);
        chk("t5_rob", int'(issue_entry.rob_num), 2);
        chk("t5_occ", int'(occupancy), 8);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        chk("t5_occ_after", int'(occupancy), 7);

        // Drain two, leaving five, then flush with dispatch and issue.
        valid_reg[20] = 1'b1;
        valid_reg[21] = 1'b1;
        step();
        chk("t6_rob10", int'(issue_entry.rob_num), 10);
        issue_ready = 1'b1;
        step();
        chk("t6_rob11", int'(issue_entry.rob_num), 11);
        step();
        issue_ready = 1'b0;
        valid_reg[22] = 1'b1;
        step();
        chk("t6_occ5", int'(occupancy), 5);
        chk("t6_rob12", int'(issue_entry.rob_num), 12);
        flush = 1'b1;
        issue_ready = 1'b1;
        dispatch_entry = mk(3, 0, 0, 3);
        dispatch_valid = 1'b1;
        step();
        flush = 1'b0;
        issue_ready = 1'b0;
        dispatch_valid = 1'b0;
        chk("t6_occ", int'(occupancy), 0);
        chk("t6_ivalid", int'(issue_valid), 0);
        chk("t6_dready", int'(dispatch_ready), 1);
        step();
        chk("t6_ivalid_hold", int'(issue_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
